// File: rtl/rgb2ycc_pkg.sv
// Shared constants for the RGB to YCbCr lane array.
// Holds the mode encoding, Q8 coefficient tables, and offset/clamp limits.
package rgb2ycc_pkg;

   typedef enum logic {
      MODE_FULL   = 1'b0,
      MODE_STUDIO = 1'b1
   } mode_e;

   localparam int SHIFT = 8;
   localparam int RND   = 128;

   // Row order Y, Cb, Cr; column order R, G, B.
   localparam int COEF_FULL [9] = '{
      77, 150, 29,
      -43, -85, 128,
      128, -107, -21
   };

   localparam int COEF_STUDIO [9] = '{
      66, 129, 25,
      -38, -74, 112,
      112, -94, -18
   };

   // 8-bit reference values, scaled by 2^(COMP_W-8) at use.
   localparam int Y_OFF  = 16;
   localparam int C_OFF  = 128;
   localparam int Y_LO_S = 16;
   localparam int Y_HI_S = 235;
   localparam int C_LO_S = 16;
   localparam int C_HI_S = 240;

   function automatic int coef(input mode_e m, input int idx);
      return (m == MODE_STUDIO) ? COEF_STUDIO[idx] : COEF_FULL[idx];
   endfunction

endpackage

// File: rtl/rgb2ycc_lane.sv
// One pixel's 3-stage datapath: products, rounded sums, offset and clamp.
// Ports: clk, rst_n, stage enables en1..en3, pix (R|G|B), mode_s1, mode_s3, y/cb/cr.
module rgb2ycc_lane
   import rgb2ycc_pkg::*;
#(
   parameter int COMP_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en1,
   input  logic                en2,
   input  logic                en3,
   input  logic [3*COMP_W-1:0] pix,
   input  logic                mode_s1,
   input  logic                mode_s3,
   output logic [COMP_W-1:0]   y,
   output logic [COMP_W-1:0]   cb,
   output logic [COMP_W-1:0]   cr
);

   localparam int PW = COMP_W + 10;
   localparam int SW = COMP_W + 11;
   localparam int SC = 1 << (COMP_W - 8);

   logic signed [PW-1:0] p_d [9];
   logic signed [PW-1:0] p_q [9];
   logic signed [SW-1:0] s_d [3];
   logic signed [SW-1:0] s_q [3];
   logic [COMP_W-1:0]    o_d [3];
   logic [COMP_W-1:0]    o_q [3];

   function automatic logic [COMP_W-1:0] fin(
      input logic signed [SW-1:0] s,
      input logic                 studio,
      input logic                 chroma
   );
      int t, lo, hi;
      t  = int'(s) + (chroma ? C_OFF * SC : (studio ? Y_OFF * SC : 0));
      lo = studio ? (chroma ? C_LO_S : Y_LO_S) * SC : 0;
      hi = studio ? (chroma ? C_HI_S : Y_HI_S) * SC : (1 << COMP_W) - 1;
      if (t < lo)
         t = lo;
      else if (t > hi)
         t = hi;
      return COMP_W'(t);
   endfunction

   // Index i: output channel i/3, input component i%3 (R at the msb).
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         p_d[i] = $signed({{(PW-COMP_W){1'b0}},
                           pix[(2 - i % 3) * COMP_W +: COMP_W]})
                * PW'(coef(mode_e'(mode_s1), i));
      end
   end

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         s_d[c] = (SW'(p_q[3*c]) + SW'(p_q[3*c+1])
                 + SW'(p_q[3*c+2]) + SW'(RND)) >>> SHIFT;
      end
   end

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         o_d[c] = fin(s_q[c], mode_s3, c != 0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '{default: '0};
         s_q <= '{default: '0};
         o_q <= '{default: '0};
      end else begin
         if (en1) p_q <= p_d;
         if (en2) s_q <= s_d;
         if (en3) o_q <= o_d;
      end
   end

   assign y  = o_q[0];
   assign cb = o_q[1];
   assign cr = o_q[2];

endmodule

// File: rtl/rgb2ycc_array.sv
// N_LANES-wide RGB to YCbCr converter with a 3-stage valid/ready pipeline.
// Ports: i_clk, i_rst (async low), i_data/i_valid/o_ready/i_mode/i_last in,
// o_luma/o_cb/o_cr/o_valid/i_ready/o_last out. Macro RGB2YCC_CHROMA422_EN
// averages chroma over lane pairs (N_LANES must then be even).
module rgb2ycc_array
   import rgb2ycc_pkg::*;
#(
   parameter int N_LANES = 8,
   parameter int COMP_W  = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [N_LANES*3*COMP_W-1:0] i_data,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic                        i_mode,
   input  logic                        i_last,
   output logic [N_LANES*COMP_W-1:0]   o_luma,
   output logic [N_LANES*COMP_W-1:0]   o_cb,
   output logic [N_LANES*COMP_W-1:0]   o_cr,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic                        o_last
);

   logic v1, v2, v3;
   logic m1, m2;
   logic l1, l2, l3;
   logic en1, en2, en3;

   logic [COMP_W-1:0] y_l  [N_LANES];
   logic [COMP_W-1:0] cb_l [N_LANES];
   logic [COMP_W-1:0] cr_l [N_LANES];

   // A stage loads when it is empty or its successor is loading too,
   // so empty slots ahead of a stall are filled.
   assign en3 = ~v3 | i_ready;
   assign en2 = ~v2 | en3;
   assign en1 = ~v1 | en2;

   assign o_ready = en1;
   assign o_valid = v3;
   assign o_last  = l3;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         m1 <= 1'b0;
         m2 <= 1'b0;
         l1 <= 1'b0;
         l2 <= 1'b0;
         l3 <= 1'b0;
      end else begin
         if (en1) begin
            v1 <= i_valid;
            m1 <= i_mode;
            l1 <= i_last;
         end
         if (en2) begin
            v2 <= v1;
            m2 <= m1;
            l2 <= l1;
         end
         if (en3) begin
            v3 <= v2;
            l3 <= l2;
         end
      end
   end

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      rgb2ycc_lane #(
         .COMP_W (COMP_W)
      ) u_lane (
         .clk     (i_clk),
         .rst_n   (i_rst),
         .en1     (en1),
         .en2     (en2),
         .en3     (en3),
         .pix     (i_data[k*3*COMP_W +: 3*COMP_W]),
         .mode_s1 (i_mode),
         .mode_s3 (m2),
         .y       (y_l[k]),
         .cb      (cb_l[k]),
         .cr      (cr_l[k])
      );
      assign o_luma[k*COMP_W +: COMP_W] = y_l[k];
   end

`ifdef RGB2YCC_CHROMA422_EN
   // Averaging after the S3 register keeps latency unchanged.
   for (genvar j = 0; j < N_LANES / 2; j++) begin : g_c422
      logic [COMP_W-1:0] cb_avg, cr_avg;
      assign cb_avg = COMP_W'(({1'b0, cb_l[2*j]} + {1'b0, cb_l[2*j+1]}
                             + (COMP_W+1)'(1)) >> 1);
      assign cr_avg = COMP_W'(({1'b0, cr_l[2*j]} + {1'b0, cr_l[2*j+1]}
                             + (COMP_W+1)'(1)) >> 1);
      assign o_cb[2*j*COMP_W +: COMP_W]     = cb_avg;
      assign o_cb[(2*j+1)*COMP_W +: COMP_W] = cb_avg;
      assign o_cr[2*j*COMP_W +: COMP_W]     = cr_avg;
      assign o_cr[(2*j+1)*COMP_W +: COMP_W] = cr_avg;
   end
`else
   for (genvar k = 0; k < N_LANES; k++) begin : g_c444
      assign o_cb[k*COMP_W +: COMP_W] = cb_l[k];
      assign o_cr[k*COMP_W +: COMP_W] = cr_l[k];
   end
`endif

endmodule

// File: tb/tb_rgb2ycc_array.sv
// Randomized self-checking bench for rgb2ycc_array against a scoreboard model.
// Honours RGB2YCC_CHROMA422_EN in the reference model as well.
module tb_rgb2ycc_array;

   localparam int L  = 8;
   localparam int C  = 8;
   localparam int DW = L * 3 * C;
   localparam int OW = L * C;
   localparam int MX = (1 << C) - 1;

   localparam int KF [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
   localparam int KS [9] = '{66, 129, 25, -38, -74, 112, 112, -94, -18};

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic          i_mode = 1'b0;
   logic          i_last = 1'b0;
   logic [OW-1:0] o_luma, o_cb, o_cr;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic          o_last;

   always #5 i_clk = ~i_clk;

   rgb2ycc_array #(
      .N_LANES (L),
      .COMP_W  (C)
   ) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_mode  (i_mode),
      .i_last  (i_last),
      .o_luma  (o_luma),
      .o_cb    (o_cb),
      .o_cr    (o_cr),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_last  (o_last)
   );

   typedef struct {
      logic [OW-1:0] y;
      logic [OW-1:0] cb;
      logic [OW-1:0] cr;
      logic          last;
      int            cyc;
      int            dy;
      int            dcb;
      int            dcr;
   } beat_t;

   beat_t q[$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    cyc = 0;
   logic  fired;

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
   endtask

   // Spec arithmetic for one output channel of one pixel.
   function automatic int comp(input int r, input int g, input int b,
                               input logic md, input int ch);
      int k [9];
      int s, sc, lo, hi;
      sc = 1 << (C - 8);
      for (int i = 0; i < 9; i++) k[i] = md ? KS[i] : KF[i];
      s = (k[3*ch]*r + k[3*ch+1]*g + k[3*ch+2]*b + 128) >>> 8;
      s = s + ((ch == 0) ? (md ? 16 * sc : 0) : 128 * sc);
      lo = md ? 16 * sc : 0;
      hi = md ? ((ch == 0) ? 235 : 240) * sc : MX;
      return (s < lo) ? lo : ((s > hi) ? hi : s);
   endfunction

   function automatic beat_t mk(input logic [DW-1:0] d, input logic md,
                                input logic lst);
      beat_t b;
      int yy [L];
      int cb [L];
      int cr [L];
      int r, g, bl, a;
      for (int k = 0; k < L; k++) begin
         r  = int'(d[k*3*C + 2*C +: C]);
         g  = int'(d[k*3*C + C +: C]);
         bl = int'(d[k*3*C +: C]);
         yy[k] = comp(r, g, bl, md, 0);
         cb[k] = comp(r, g, bl, md, 1);
         cr[k] = comp(r, g, bl, md, 2);
      end
`ifdef RGB2YCC_CHROMA422_EN
      for (int j = 0; j < L / 2; j++) begin
         a = (cb[2*j] + cb[2*j+1] + 1) / 2;
         cb[2*j] = a;
         cb[2*j+1] = a;
         a = (cr[2*j] + cr[2*j+1] + 1) / 2;
         cr[2*j] = a;
         cr[2*j+1] = a;
      end
`endif
      for (int k = 0; k < L; k++) begin
         b.y[k*C +: C]  = C'(yy[k]);
         b.cb[k*C +: C] = C'(cb[k]);
         b.cr[k*C +: C] = C'(cr[k]);
      end
      b.last = lst;
      b.cyc  = 0;
      b.dy   = -1;
      b.dcb  = -1;
      b.dcr  = -1;
      return b;
   endfunction

   // One clock: drive, check outputs against the scoreboard, advance.
   task automatic step(input logic v, input logic rdy,
                       input logic [DW-1:0] d, input logic md,
                       input logic lst, input int ey = -1,
                       input int ecb = -1, input int ecr = -1);
      beat_t b;
      logic  exp_v;
      i_valid = v;
      i_ready = rdy;
      i_data  = d;
      i_mode  = md;
      i_last  = lst;
      #1;
      check("o_ready", o_ready, rdy || q.size() < 3);
      exp_v = (q.size() > 0) && (cyc - q[0].cyc >= 3);
      check("o_valid", o_valid, exp_v);
      if (exp_v) begin
         check("luma", o_luma, q[0].y);
         check("cb", o_cb, q[0].cb);
         check("cr", o_cr, q[0].cr);
         check("last", o_last, q[0].last);
         if (q[0].dy >= 0) begin
            check("y_lane0", o_luma[C-1:0], q[0].dy);
            check("cb_lane0", o_cb[C-1:0], q[0].dcb);
            check("cr_lane0", o_cr[C-1:0], q[0].dcr);
         end
         if (rdy) void'(q.pop_front());
      end
      fired = v && o_ready;
      if (fired) begin
         b = mk(d, md, lst);
         b.cyc = cyc;
         b.dy  = ey;
         b.dcb = ecb;
         b.dcr = ecr;
         q.push_back(b);
      end
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 40) begin
         step(1'b0, 1'b1, '0, 1'b0, 1'b0);
         n++;
      end
      check("drain", q.size(), 0);
   endtask

   function automatic logic [DW-1:0] fill(input int r, input int g,
                                          input int b);
      logic [DW-1:0] d;
      for (int k = 0; k < L; k++)
         d[k*3*C +: 3*C] = {C'(r), C'(g), C'(b)};
      return d;
   endfunction

   function automatic logic [DW-1:0] rand_pix();
      logic [DW-1:0] d;
      int v;
      for (int k = 0; k < 3 * L; k++) begin
         case ($urandom % 4)
            0: v = 0;
            1: v = MX;
            default: v = int'($urandom_range(0, MX));
         endcase
         d[k*C +: C] = C'(v);
      end
      return d;
   endfunction

   logic [DW-1:0] bd [10];
   logic [DW-1:0] d2;
   int            k, t;

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_valid", o_valid, 1'b0);
      check("rst_last", o_last, 1'b0);
      check("rst_luma", o_luma, '0);
      check("rst_cb", o_cb, '0);
      check("rst_cr", o_cr, '0);
      check("rst_ready", o_ready, 1'b1);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;

      // White then black, full range.
      step(1, 1, fill(MX, MX, MX), 0, 0, 255, 128, 128);
      step(1, 1, fill(0, 0, 0), 0, 0, 0, 128, 128);
      drain();

      // Red: Cr clamps from 256.
      step(1, 1, fill(MX, 0, 0), 0, 0, 77, 85, 255);
      drain();

      // Studio range with mode alternating per beat.
      step(1, 1, fill(MX, MX, MX), 1, 0, 235, 128, 128);
      step(1, 1, fill(MX, MX, MX), 0, 0, 255, 128, 128);
      step(1, 1, fill(0, 0, 0), 1, 0, 16, 128, 128);
      step(1, 1, fill(0, 0, 0), 0, 0, 0, 128, 128);
      drain();

      // Red/blue lane pair for chroma averaging.
      d2 = fill(0, 0, 0);
      d2[3*C-1:0]   = {C'(MX), C'(0), C'(0)};
      d2[6*C-1:3*C] = {C'(0), C'(0), C'(MX)};
`ifdef RGB2YCC_CHROMA422_EN
      step(1, 1, d2, 0, 0, 77, 170, 181);
`else
      step(1, 1, d2, 0, 0, 77, 85, 255);
`endif
      drain();

      // Ten beats with a downstream stall on cycles 4..8.
      for (int i = 0; i < 10; i++) bd[i] = rand_pix();
      k = 0;
      t = 1;
      while (k < 10 && t < 60) begin
         step(1, !(t >= 4 && t <= 8), bd[k], k[0], k == 9);
         if (fired) k++;
         t++;
      end
      check("stream_cnt", k, 10);
      drain();

      // Reset with two beats in flight.
      step(1, 1, rand_pix(), 0, 1);
      step(1, 1, rand_pix(), 1, 0);
      step(0, 1, '0, 0, 0);
      i_rst = 1'b0;
      #1;
      check("mid_rst_valid", o_valid, 1'b0);
      check("mid_rst_last", o_last, 1'b0);
      check("mid_rst_luma", o_luma, '0);
      check("mid_rst_cb", o_cb, '0);
      check("mid_rst_cr", o_cr, '0);
      check("mid_rst_ready", o_ready, 1'b1);
      q.delete();
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      repeat (4) step(0, 1, '0, 0, 0);
      step(1, 1, fill(MX, MX, MX), 0, 0, 255, 128, 128);
      drain();

      // Random traffic with random backpressure and modes.
      repeat (800) begin
         step(($urandom % 4) != 0, ($urandom % 3) != 0, rand_pix(),
              1'($urandom), 1'($urandom));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
